// File: rtl/priority_decoder_pkg.sv
// Shared FSM state type and index-width helper for priority_decoder and priority_encoder.
package priority_decoder_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_e;

    // Smallest index width able to address 'width' positions (minimum 1).
    function automatic int idx_width(input int width);
        int w;
        w = 1;
        for (int i = 1; i < 16; i++) begin
            if ((32'd1 << i) < width) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational lowest-set-bit encoder; reports 0 when no bit is set.
module priority_encoder
    import priority_decoder_pkg::*;
#(
    parameter  int INPUT_WIDTH = 8,
    localparam int OUT_W       = idx_width(INPUT_WIDTH)
) (
    input  logic [INPUT_WIDTH-1:0] in_bits,
    output logic [OUT_W-1:0]       first_idx
);

    // Scan downward so the lowest set bit is the final value written.
    always_comb begin
        first_idx = '0;
        for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
            if (in_bits[i]) begin
                first_idx = OUT_W'(i);
            end else begin
                first_idx = first_idx;
            end
        end
    end

endmodule

// File: rtl/priority_decoder.sv
// Accumulates index beats into a bitmap and emits each group with its lowest set position.
// Optional build macro: PRIORITY_DECODER_ASSERT_EN adds immediate output-consistency assertions.
module priority_decoder
    import priority_decoder_pkg::*;
#(
    parameter  int OUTPUT_WIDTH = 8,
    localparam int IDX_W        = $clog2(OUTPUT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W-1:0]        in_index,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_bits,
    output logic [IDX_W-1:0]        out_first,
    output logic                    out_err
);

    state_e                  state_q, state_d;
    logic [OUTPUT_WIDTH-1:0] mask_q, mask_d;
    logic [OUTPUT_WIDTH-1:0] onehot_s;
    logic                    err_q, err_d;
    logic                    in_range_s;
    logic                    in_ready_s, out_valid_s;

    assign onehot_s   = {{(OUTPUT_WIDTH-1){1'b0}}, 1'b1} << in_index;
    // Only non-power-of-two widths can actually see an out-of-range index.
    assign in_range_s = ({1'b0, in_index} < (IDX_W+1)'(OUTPUT_WIDTH));

    // Next-state, mask/error accumulation and handshake decode.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        err_d       = err_q;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    if (in_range_s) begin
                        mask_d = mask_q | onehot_s;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = EMIT;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            EMIT: begin
                out_valid_s = 1'b1;
                if (out_ready) begin
                    state_d = ACCUM;
                    mask_d  = '0;
                    err_d   = 1'b0;
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = ACCUM;
                mask_d  = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // State, mask and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    priority_encoder #(
        .INPUT_WIDTH(OUTPUT_WIDTH)
    ) u_first (
        .in_bits  (mask_q),
        .first_idx(out_first)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_bits  = mask_q;
    assign out_err   = err_q;

`ifdef PRIORITY_DECODER_ASSERT_EN
    logic [OUTPUT_WIDTH-1:0] hold_bits_q;
    logic                    hold_q;

    // Remember whether the previous cycle was a stalled emission.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= 1'b0;
            hold_bits_q <= '0;
        end else begin
            hold_q      <= out_valid_s && !out_ready;
            hold_bits_q <= mask_q;
        end
    end

    // Lowest-position consistency and stall stability of the presented group.
    always_ff @(posedge clk) begin
        if (!rst && out_valid_s) begin
            if (mask_q != '0) begin
                assert (mask_q[out_first] == 1'b1);
                assert ((mask_q & ((OUTPUT_WIDTH'(1) << out_first) - OUTPUT_WIDTH'(1))) == '0);
            end
            if (hold_q) begin
                assert (mask_q == hold_bits_q);
            end
        end
    end
`endif

endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
- REQ-001: Parameter OUTPUT_WIDTH, default 8: width of the decoded bitmap; legal range 2..64.
- REQ-002: Derived localparam IDX_W = $clog2(OUTPUT_WIDTH): index width. Not overridable.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: in_valid  input  1  an index beat is offered.
- REQ-006: in_ready  output  1  the block accepts the offered beat.
- REQ-007: in_index  input  IDX_W  encoded bit position to set.
- REQ-008: in_last  input  1  final beat of the current group.
- REQ-009: out_valid  output  1  the decoded group is presented.
- REQ-010: out_ready  input  1  the consumer accepts the group.
- REQ-011: out_bits  output  OUTPUT_WIDTH  accumulated one-hot-OR bitmap.
- REQ-012: out_first  output  IDX_W  lowest set position of out_bits; 0 when out_bits is zero.
- REQ-013: out_err  output  1  at least one beat in the group carried in_index >= OUTPUT_WIDTH.

Function
- REQ-014: Two-state FSM: ACCUM and EMIT.
- REQ-015: ACCUM: in_ready=1, out_valid=0.
- REQ-016: EMIT: in_ready=0, out_valid=1.
- REQ-017: A beat is accepted when in_valid and in_ready are both 1 in the same cycle.
- REQ-018: An accepted beat with an in-range index ORs (1 << in_index) into the mask; duplicate indices are idempotent.
- REQ-019: An accepted beat with an out-of-range index leaves the mask unchanged and sets the sticky error flag.
- REQ-020: An accepted beat with in_last=1 moves ACCUM to EMIT; that beat's index is included in the mask.
- REQ-021: Latency: last beat accepted at edge N gives out_valid=1 from cycle N+1, with the final bitmap on out_bits.
- REQ-022: In EMIT, out_bits, out_first and out_err hold stable until out_ready=1.
- REQ-023: EMIT with out_ready=1 returns to ACCUM at the next edge, clearing mask and error. No beat is accepted in that cycle.
- REQ-024: A group may be empty of valid indices (for example, a single out-of-range last beat). It still emits, with out_bits=0, out_first=0 and out_err=1.
- REQ-025: out_first is derived combinationally from the registered mask, so it is glitch-free relative to out_valid.
- REQ-026: in_index and in_last are ignored whenever in_valid=0.

Reset
- REQ-027: When rst is asserted: FSM=ACCUM, mask=0, error=0. Outputs: out_valid=0, in_ready=1, out_bits=0, out_first=0, out_err=0.
- REQ-028: Reset mid-group or mid-EMIT discards the partial or pending group with no output beat.
- REQ-029: First acceptance is possible in the first cycle after rst deasserts.

Configuration
- REQ-030: Macro PRIORITY_DECODER_ASSERT_EN enables immediate assertions, checked whenever out_valid=1:
  - out_bits[out_first] is 1 when out_bits is nonzero;
  - no bit below out_first is set;
  - out_bits is stable while out_valid=1 and out_ready=0.
- REQ-031: Without PRIORITY_DECODER_ASSERT_EN, no assertion code is elaborated and functional behaviour is identical.

Structure
- REQ-032: Package priority_decoder_pkg holds the FSM state enum (ACCUM, EMIT) and an index-width helper function.
- REQ-033: out_first comes from one instance of the existing priority_encoder sub-module, with INPUT_WIDTH=OUTPUT_WIDTH, fed by the mask register.

Verification
- REQ-034: OUTPUT_WIDTH=8, beats 5, 2, 7(last) -> one cycle later out_valid=1, out_bits=8'b1010_0100, out_first=2, out_err=0.
- REQ-035: OUTPUT_WIDTH=8, out_ready held 0 for 4 cycles in EMIT -> in_ready=0 and outputs unchanged throughout. out_ready=1 -> next cycle ACCUM with mask 0.
- REQ-036: OUTPUT_WIDTH=5, beats 6, 1(last) -> out_bits=5'b00010, out_first=1, out_err=1.
- REQ-037: OUTPUT_WIDTH=8, beats 3, 3, 3(last) -> out_bits=8'h08, out_first=3.
- REQ-038: Assert rst after beats 0 and 4 (no last), then send 6(last) -> out_bits=8'h40; the earlier beats never appear.
- REQ-039: OUTPUT_WIDTH=2, single beat 1(last) -> out_bits=2'b10, out_first=1. Round-trip check: out_first equals the lowest index sent across random groups.
